qkv_linear_sched: RTL and testbench

Pass scheduler for the linear-layer engine in the MHSA accelerator. It accepts a command naming which projections to compute (Q, K, V), then runs them in order. For each pass it selects the weight region, holds the engine's `start` until the engine reports `done`, and inserts a settle gap between passes. It also provides a per-pass watchdog, abort, and status.

---
 rtl/qkv_linear_sched_if.sv | 26 ++
 rtl/qkv_linear_sched.sv | 128 ++++++++++++
 tb/tb_qkv_linear_sched.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/qkv_linear_sched_if.sv
// Command, status and engine handshake bundle for the QKV pass scheduler.
// The slave modport is the scheduler side; master is the controller/engine side.
interface qkv_linear_sched_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_mask;
    logic        abort;
    logic        busy;
    logic        done;
    logic        err;
    logic [2:0]  pass_done;
    logic        lin_start;
    logic        lin_done;
    logic [1:0]  pass_sel;
    logic [31:0] weight_base;

    modport master (
        output cmd_valid, cmd_mask, abort, lin_done,
        input  cmd_ready, busy, done, err, pass_done, lin_start, pass_sel, weight_base
    );

    modport slave (
        input  cmd_valid, cmd_mask, abort, lin_done,
        output cmd_ready, busy, done, err, pass_done, lin_start, pass_sel, weight_base
    );
endinterface

// File: rtl/qkv_linear_sched.sv
// Runs the selected Q/K/V linear-engine passes in order.
// Each pass has a settle gap, a watchdog and an abort path.
module qkv_linear_sched #(
    parameter int unsigned GAP_CYCLES    = 2,
    parameter int unsigned TIMEOUT       = 12000,
    parameter logic [31:0] WEIGHT_STRIDE = 32'd2048
) (
    input logic               clk,
    input logic               rst_n,
    qkv_linear_sched_if.slave bus
);

    typedef enum logic [1:0] {IDLE, PICK, RUN, GAP} state_e;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
    localparam logic [3:0]  GAP_LAST = 4'(GAP_CYCLES - 1);

    state_e      state_q;
    logic [2:0]  remain_q;
    logic [2:0]  pass_done_q;
    logic [1:0]  pass_sel_q;
    logic [31:0] weight_base_q;
    logic        err_q;
    logic        done_q;
    logic [15:0] tmo_q;
    logic [3:0]  gap_q;

    logic [1:0]  sel_d;
    logic [31:0] base_d;
    logic [2:0]  sel_oh;

    // Lowest remaining pass wins, which yields the fixed Q, K, V order.
    always_comb begin
        sel_d = 2'd2;
        if (remain_q[0]) begin
            sel_d = 2'd0;
        end else if (remain_q[1]) begin
            sel_d = 2'd1;
        end
    end

    assign base_d = 32'(sel_d) * WEIGHT_STRIDE;
    assign sel_oh = 3'b001 << pass_sel_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            remain_q      <= '0;
            pass_done_q   <= '0;
            pass_sel_q    <= '0;
            weight_base_q <= '0;
            err_q         <= 1'b0;
            done_q        <= 1'b0;
            tmo_q         <= '0;
            gap_q         <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        remain_q    <= bus.cmd_mask;
                        err_q       <= 1'b0;
                        pass_done_q <= '0;
                        if (bus.cmd_mask != 3'b000) begin
                            state_q <= PICK;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                PICK: begin
                    if (bus.abort) begin
                        state_q <= IDLE;
                    end else begin
                        pass_sel_q    <= sel_d;
                        weight_base_q <= base_d;
                        tmo_q         <= '0;
                        state_q       <= RUN;
                    end
                end
                RUN: begin
                    if (tmo_q != '1) begin
                        tmo_q <= tmo_q + 16'd1;
                    end
                    // abort beats lin_done, which beats a coincident timeout
                    if (bus.abort) begin
                        state_q <= IDLE;
                    end else if (bus.lin_done) begin
                        remain_q    <= remain_q & ~sel_oh;
                        pass_done_q <= pass_done_q | sel_oh;
                        gap_q       <= '0;
                        state_q     <= GAP;
                    end else if (tmo_q >= TMO_LAST) begin
                        err_q    <= 1'b1;
                        done_q   <= 1'b1;
                        remain_q <= '0;
                        state_q  <= IDLE;
                    end
                end
                GAP: begin
                    if (bus.abort) begin
                        state_q <= IDLE;
                    end else if (gap_q == GAP_LAST) begin
                        if (remain_q != 3'b000) begin
                            state_q <= PICK;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end
                    end else begin
                        gap_q <= gap_q + 4'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready   = (state_q == IDLE);
    assign bus.busy        = (state_q != IDLE);
    assign bus.lin_start   = (state_q == RUN);
    assign bus.done        = done_q;
    assign bus.err         = err_q;
    assign bus.pass_done   = pass_done_q;
    assign bus.pass_sel    = pass_sel_q;
    assign bus.weight_base = weight_base_q;

endmodule

// File: tb/tb_qkv_linear_sched.sv
// Directed bench for qkv_linear_sched: a vector table of commands plus
// hand-written timeout, idle-input and mid-run reset sequences.
module tb_qkv_linear_sched;

    localparam int GAP = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    qkv_linear_sched_if bus ();
    qkv_linear_sched_if tbus ();

    qkv_linear_sched #(
        .GAP_CYCLES    (GAP),
        .TIMEOUT       (12000),
        .WEIGHT_STRIDE (32'd2048)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    qkv_linear_sched #(
        .GAP_CYCLES    (GAP),
        .TIMEOUT       (50),
        .WEIGHT_STRIDE (32'd2048)
    ) u_tmo (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (tbus)
    );

    typedef struct {
        logic [2:0] mask;
        int         lat;        // RUN cycles before the engine answers
        int         abort_win;  // window index to abort in, -1 for none
        int         abort_cyc;  // RUN cycle of that window carrying abort
        logic       gap_pulse;  // stray lin_done in first GAP cycle
        int         exp_nwin;
        logic [5:0] exp_sels;   // {sel2, sel1, sel0}
        logic [2:0] exp_pd;
        logic       exp_done;
    } vec_t;

    vec_t vecs[8];

    int n_checks = 0;
    int n_fail   = 0;

    int         nwin, lead, done_during, end_done, done_after, bound_hit, sel_glitch;
    int         win_len[3];
    logic [1:0] win_sel[3];
    logic [31:0] win_base[3];
    int         gap_low[3];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_cmd(input vec_t v);
        int runlen;
        int lowlen;
        int cyc;
        runlen = 0; lowlen = 0; cyc = 0;
        nwin = 0; lead = -1; done_during = 0; sel_glitch = 0; bound_hit = 0;
        for (int i = 0; i < 3; i++) begin
            win_len[i] = 0; win_sel[i] = 2'd3; win_base[i] = '1; gap_low[i] = -1;
        end
        bus.cmd_mask  = v.mask;
        bus.cmd_valid = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.cmd_mask  = 3'b000;
        while (bus.busy && cyc < 3000) begin
            if (bus.done) done_during++;
            if (bus.lin_start) begin
                if (runlen == 0 && nwin < 3) begin
                    win_sel[nwin]  = bus.pass_sel;
                    win_base[nwin] = bus.weight_base;
                    if (nwin == 0) lead = lowlen;
                    else gap_low[nwin-1] = lowlen;
                end
                if (nwin < 3 && bus.pass_sel != win_sel[nwin]) sel_glitch++;
                runlen++;
                bus.lin_done = (runlen == v.lat);
                bus.abort    = (nwin == v.abort_win && runlen == v.abort_cyc);
            end else begin
                bus.lin_done = 1'b0;
                if (runlen > 0) begin
                    if (nwin < 3) win_len[nwin] = runlen;
                    nwin++;
                    runlen = 0;
                    lowlen = 0;
                    bus.lin_done = v.gap_pulse && (nwin == 1);
                end
                bus.abort = 1'b0;
                lowlen++;
            end
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 3000) bound_hit = 1;
        if (runlen > 0) begin
            if (nwin < 3) win_len[nwin] = runlen;
            nwin++;
        end
        bus.lin_done = 1'b0;
        bus.abort    = 1'b0;
        end_done = int'(bus.done);
        @(negedge clk);
        done_after = int'(bus.done);
    endtask

    task automatic tmo_run(output int hi, output int dd, output int cyc);
        hi = 0; dd = 0; cyc = 0;
        tbus.cmd_mask  = 3'b001;
        tbus.cmd_valid = 1'b1;
        @(negedge clk);
        tbus.cmd_valid = 1'b0;
        while (tbus.busy && cyc < 500) begin
            if (tbus.lin_start) hi++;
            if (tbus.done) dd++;
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        vec_t       v;
        logic [5:0] sels;
        logic [1:0] s;
        logic [1:0] s_last;
        int         hi, dd, cyc;

        vecs[0] = '{3'b111, 100, -1,  0, 1'b0, 3, 6'b10_01_00, 3'b111, 1'b1};
        vecs[1] = '{3'b101, 100, -1,  0, 1'b0, 2, 6'b00_10_00, 3'b101, 1'b1};
        vecs[2] = '{3'b010,   7, -1,  0, 1'b0, 1, 6'b00_00_01, 3'b010, 1'b1};
        vecs[3] = '{3'b100,   1, -1,  0, 1'b0, 1, 6'b00_00_10, 3'b100, 1'b1};
        vecs[4] = '{3'b111, 100,  1, 30, 1'b0, 2, 6'b00_01_00, 3'b001, 1'b0};
        vecs[5] = '{3'b011,  20,  0, 20, 1'b0, 1, 6'b00_00_00, 3'b000, 1'b0};
        vecs[6] = '{3'b011,  10, -1,  0, 1'b1, 2, 6'b00_01_00, 3'b011, 1'b1};
        vecs[7] = '{3'b000,   5, -1,  0, 1'b0, 0, 6'b00_00_00, 3'b000, 1'b1};

        bus.cmd_valid = 1'b0; bus.cmd_mask = 3'b000; bus.abort = 1'b0; bus.lin_done = 1'b0;
        tbus.cmd_valid = 1'b0; tbus.cmd_mask = 3'b000; tbus.abort = 1'b0; tbus.lin_done = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_cmd_ready", int'(bus.cmd_ready), 1);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_err", int'(bus.err), 0);
        check("rst_lin_start", int'(bus.lin_start), 0);
        check("rst_pass_done", int'(bus.pass_done), 0);
        check("rst_pass_sel", int'(bus.pass_sel), 0);
        check("rst_weight_base", int'(bus.weight_base), 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int t = 0; t < 8; t++) begin
            v = vecs[t];
            run_cmd(v);
            sels = v.exp_sels;
            s_last = 2'd0;
            check($sformatf("v%0d_bound", t), bound_hit, 0);
            check($sformatf("v%0d_nwin", t), nwin, v.exp_nwin);
            for (int w = 0; w < v.exp_nwin && w < 3; w++) begin
                s = sels[2*w +: 2];
                s_last = s;
                check($sformatf("v%0d_sel%0d", t, w), int'(win_sel[w]), int'(s));
                check($sformatf("v%0d_base%0d", t, w), int'(win_base[w]), int'(s) * 2048);
                check($sformatf("v%0d_len%0d", t, w), win_len[w],
                      (v.abort_win == w) ? v.abort_cyc : v.lat);
                if (w > 0) check($sformatf("v%0d_gap%0d", t, w), gap_low[w-1], GAP + 1);
            end
            if (v.exp_nwin > 0) begin
                check($sformatf("v%0d_lead", t), lead, 1);
                check($sformatf("v%0d_idle_sel", t), int'(bus.pass_sel), int'(s_last));
                check($sformatf("v%0d_idle_base", t), int'(bus.weight_base), int'(s_last) * 2048);
            end
            check($sformatf("v%0d_sel_glitch", t), sel_glitch, 0);
            check($sformatf("v%0d_done_busy", t), done_during, 0);
            check($sformatf("v%0d_done", t), end_done, int'(v.exp_done));
            check($sformatf("v%0d_done_len", t), done_after, 0);
            check($sformatf("v%0d_pass_done", t), int'(bus.pass_done), int'(v.exp_pd));
            check($sformatf("v%0d_err", t), int'(bus.err), 0);
            check($sformatf("v%0d_cmd_ready", t), int'(bus.cmd_ready), 1);
        end

        // abort and stray lin_done while idle
        bus.abort = 1'b1;
        bus.lin_done = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        bus.lin_done = 1'b0;
        @(negedge clk);
        check("idle_in_busy", int'(bus.busy), 0);
        check("idle_in_ready", int'(bus.cmd_ready), 1);
        check("idle_in_done", int'(bus.done), 0);
        check("idle_in_pass_done", int'(bus.pass_done), 0);

        // watchdog with an engine that never answers
        tmo_run(hi, dd, cyc);
        check("tmo_bound", int'(cyc < 500), 1);
        check("tmo_len", hi, 50);
        check("tmo_done_busy", dd, 0);
        check("tmo_done", int'(tbus.done), 1);
        check("tmo_err", int'(tbus.err), 1);
        check("tmo_pass_done", int'(tbus.pass_done), 0);
        @(negedge clk);
        check("tmo_done_len", int'(tbus.done), 0);
        check("tmo_err_sticky", int'(tbus.err), 1);
        tbus.cmd_mask = 3'b000;
        tbus.cmd_valid = 1'b1;
        @(negedge clk);
        tbus.cmd_valid = 1'b0;
        check("tmo_err_clear", int'(tbus.err), 0);
        check("tmo_zero_done", int'(tbus.done), 1);
        @(negedge clk);

        // err set again so the reset below has something to clear
        tmo_run(hi, dd, cyc);
        check("tmo2_err", int'(tbus.err), 1);

        bus.cmd_mask = 3'b010;
        bus.cmd_valid = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        repeat (12) @(negedge clk);
        check("pre_rst_start", int'(bus.lin_start), 1);
        check("pre_rst_base", int'(bus.weight_base), 2048);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", int'(bus.cmd_ready), 1);
        check("mid_rst_busy", int'(bus.busy), 0);
        check("mid_rst_start", int'(bus.lin_start), 0);
        check("mid_rst_sel", int'(bus.pass_sel), 0);
        check("mid_rst_base", int'(bus.weight_base), 0);
        check("mid_rst_pass_done", int'(bus.pass_done), 0);
        check("mid_rst_done", int'(bus.done), 0);
        check("mid_rst_err", int'(tbus.err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
